// File: rtl/ttc_chanb_cmd_decoder_if.sv
// Channel-B command decoder bus: broadcast strobe inputs, fill-type and error
// status outputs, and the optional command-log read port.
interface ttc_chanb_cmd_decoder_if #(
   parameter int CMD_W       = 6,
   parameter int FILL_TYPE_W = 2,
   parameter int CNT_W       = 32
);
   logic [CMD_W-1:0]       chan_b_info;
   logic                   chan_b_valid;
   logic                   evt_count_reset;
   logic                   fill_start;
   logic [CNT_W-1:0]       thres_unknown;
   logic                   err_clr;
   logic [FILL_TYPE_W-1:0] fill_type;
   logic [FILL_TYPE_W-1:0] fill_type_pending;
   logic                   reset_trig_num;
   logic                   reset_trig_timestamp;
   logic [CNT_W-1:0]       unknown_cmd_count;
   logic                   error_unknown;
   logic                   log_rd_en;
   logic [CMD_W:0]         log_dout;
   logic                   log_empty;
   logic                   log_overflow;

   modport master (
      output chan_b_info, chan_b_valid, evt_count_reset, fill_start,
             thres_unknown, err_clr, log_rd_en,
      input  fill_type, fill_type_pending, reset_trig_num, reset_trig_timestamp,
             unknown_cmd_count, error_unknown, log_dout, log_empty, log_overflow
   );

   modport slave (
      input  chan_b_info, chan_b_valid, evt_count_reset, fill_start,
             thres_unknown, err_clr, log_rd_en,
      output fill_type, fill_type_pending, reset_trig_num, reset_trig_timestamp,
             unknown_cmd_count, error_unknown, log_dout, log_empty, log_overflow
   );
endinterface

// File: rtl/ttc_chanb_cmd_decoder.sv
// TTC channel-B broadcast command decoder.
// Decodes fill-type and timestamp-reset commands, pulses the trigger-number
// reset, counts unrecognised commands against a threshold, and (when the
// TTC_CHANB_LOG_EN macro is defined) keeps a first-word-fall-through log of
// every strobed command. Without TTC_CHANB_LOG_EN the log port reads as an
// always-empty, never-overflowing FIFO.
module ttc_chanb_cmd_decoder #(
   parameter int CMD_W       = 6,
   parameter int FILL_TYPE_W = 2,
   parameter int CNT_W       = 32,
   parameter int DEFER_FILL  = 1,
   parameter int LOG_DEPTH   = 16
) (
   input logic                   clk,
   input logic                   reset,
   ttc_chanb_cmd_decoder_if.slave bus
);

   localparam logic [FILL_TYPE_W-1:0] FILL_MUON = {{(FILL_TYPE_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]       CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]             cmd_class;
   logic [FILL_TYPE_W-1:0] fill_field;
   logic                   is_ts_cmd;
   logic                   is_fill_cmd;
   logic                   is_unknown;

   logic [FILL_TYPE_W-1:0] fill_type_q, fill_type_d;
   logic [FILL_TYPE_W-1:0] fill_type_pending_q, fill_type_pending_d;
   logic                   reset_trig_num_q, reset_trig_num_d;
   logic                   reset_trig_timestamp_q, reset_trig_timestamp_d;
   logic [CNT_W-1:0]       unknown_cmd_count_q, unknown_cmd_count_d;
   logic                   error_unknown_q, error_unknown_d;

   // Not every input bit is consumed in every build (fill_start with immediate
   // fill, log_rd_en without the log, low info bits).
   logic unused_inputs;
   assign unused_inputs = ^{bus.fill_start, bus.log_rd_en, bus.chan_b_info};

   // Classify the strobed command: timestamp reset, fill-type change, or unknown.
   always_comb begin
      cmd_class   = bus.chan_b_info[CMD_W-1 -: 3];
      fill_field  = bus.chan_b_info[CMD_W-2 -: FILL_TYPE_W];
      is_ts_cmd   = bus.chan_b_valid && (cmd_class == 3'b001) && bus.chan_b_info[1];
      is_fill_cmd = bus.chan_b_valid && bus.chan_b_info[CMD_W-1] &&
                    !bus.chan_b_info[1] && (fill_field != '0);
      is_unknown  = bus.chan_b_valid && !is_fill_cmd && !is_ts_cmd;
   end

   // Trigger-reset pulses are one cycle long, registered straight from the strobe.
   always_comb begin
      reset_trig_num_d       = bus.chan_b_valid && bus.evt_count_reset;
      reset_trig_timestamp_d = is_ts_cmd;
   end

   // Stage the new fill type; the active type follows either at the next fill
   // boundary (deferred) or together with the staged value (immediate).
   always_comb begin
      fill_type_pending_d = fill_type_pending_q;
      fill_type_d         = fill_type_q;
      if (is_fill_cmd) begin
         fill_type_pending_d = fill_field;
      end
      if (DEFER_FILL != 0) begin
         // The old staged value moves up even if a new one arrives this cycle.
         if (bus.fill_start) begin
            fill_type_d = fill_type_pending_q;
         end
      end else if (is_fill_cmd) begin
         fill_type_d = fill_field;
      end
   end

   // Saturating unknown-command counter; a clear beats a same-cycle increment.
   always_comb begin
      unknown_cmd_count_d = unknown_cmd_count_q;
      if (bus.err_clr) begin
         unknown_cmd_count_d = '0;
      end else if (is_unknown && (unknown_cmd_count_q != CNT_MAX)) begin
         unknown_cmd_count_d = unknown_cmd_count_q + CNT_ONE;
      end
   end

   // Error flag trails the registered count by one cycle.
   always_comb begin
      error_unknown_d = unknown_cmd_count_q > bus.thres_unknown;
   end

   // Decoder state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         fill_type_q            <= FILL_MUON;
         fill_type_pending_q    <= FILL_MUON;
         reset_trig_num_q       <= 1'b0;
         reset_trig_timestamp_q <= 1'b0;
         unknown_cmd_count_q    <= '0;
         error_unknown_q        <= 1'b0;
      end else begin
         fill_type_q            <= fill_type_d;
         fill_type_pending_q    <= fill_type_pending_d;
         reset_trig_num_q       <= reset_trig_num_d;
         reset_trig_timestamp_q <= reset_trig_timestamp_d;
         unknown_cmd_count_q    <= unknown_cmd_count_d;
         error_unknown_q        <= error_unknown_d;
      end
   end

   assign bus.fill_type            = fill_type_q;
   assign bus.fill_type_pending    = fill_type_pending_q;
   assign bus.reset_trig_num       = reset_trig_num_q;
   assign bus.reset_trig_timestamp = reset_trig_timestamp_q;
   assign bus.unknown_cmd_count    = unknown_cmd_count_q;
   assign bus.error_unknown        = error_unknown_q;

`ifdef TTC_CHANB_LOG_EN
   localparam int AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Pointers carry one wrap bit so full and empty are distinguishable.
   logic [CMD_W:0] log_mem_q [LOG_DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic           log_overflow_q, log_overflow_d;
   logic           log_empty;
   logic           log_full;
   logic           log_push;
   logic           log_pop;

   // Push every strobe; a full log still accepts if a pop frees a slot this cycle.
   always_comb begin
      log_empty      = (wr_ptr_q == rd_ptr_q);
      log_full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
      log_pop        = bus.log_rd_en && !log_empty;
      log_push       = bus.chan_b_valid && (!log_full || log_pop);
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      log_overflow_d = log_overflow_q;
      if (log_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (log_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (bus.chan_b_valid && log_full && !log_pop) begin
         log_overflow_d = 1'b1;
      end
   end

   // Log pointers and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         log_overflow_q <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         log_overflow_q <= log_overflow_d;
      end
   end

   // Log storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (!reset && log_push) begin
         log_mem_q[wr_ptr_q[AW-1:0]] <= {bus.evt_count_reset, bus.chan_b_info};
      end
   end

   assign bus.log_dout     = log_mem_q[rd_ptr_q[AW-1:0]];
   assign bus.log_empty    = log_empty;
   assign bus.log_overflow = log_overflow_q;
`else
   assign bus.log_dout     = '0;
   assign bus.log_empty    = 1'b1;
   assign bus.log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ttc_chanb_cmd_decoder.sv
// Bench for ttc_chanb_cmd_decoder: two instances (deferred fill with a 32-bit
// counter, immediate fill with a 4-bit counter) share one stimulus stream and
// are compared every cycle against a behavioural model, after a set of
// directed scenarios.
module tb_ttc_chanb_cmd_decoder;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  info;
   logic        valid, evt, fs, clr, rd;
   logic [31:0] thres;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ttc_chanb_cmd_decoder_if #(.CMD_W(6), .FILL_TYPE_W(2), .CNT_W(32)) bus_a ();
   ttc_chanb_cmd_decoder_if #(.CMD_W(6), .FILL_TYPE_W(2), .CNT_W(4))  bus_b ();

   assign bus_a.chan_b_info     = info;
   assign bus_a.chan_b_valid    = valid;
   assign bus_a.evt_count_reset = evt;
   assign bus_a.fill_start      = fs;
   assign bus_a.thres_unknown   = thres;
   assign bus_a.err_clr         = clr;
   assign bus_a.log_rd_en       = rd;
   assign bus_b.chan_b_info     = info;
   assign bus_b.chan_b_valid    = valid;
   assign bus_b.evt_count_reset = evt;
   assign bus_b.fill_start      = fs;
   assign bus_b.thres_unknown   = thres[3:0];
   assign bus_b.err_clr         = clr;
   assign bus_b.log_rd_en       = rd;

   ttc_chanb_cmd_decoder #(.CMD_W(6), .FILL_TYPE_W(2), .CNT_W(32),
                           .DEFER_FILL(1), .LOG_DEPTH(DEPTH))
      dut_a (.clk(clk), .reset(reset), .bus(bus_a));

   ttc_chanb_cmd_decoder #(.CMD_W(6), .FILL_TYPE_W(2), .CNT_W(4),
                           .DEFER_FILL(0), .LOG_DEPTH(DEPTH))
      dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   // Behavioural model state
   int     m_fill_a, m_pend_a, m_fill_b, m_pend_b;
   int     m_num, m_ts, m_err_a, m_err_b, m_ovf;
   longint m_cnt_a;
   int     m_cnt_b;
   int     m_log[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fill_a = 1; m_pend_a = 1; m_fill_b = 1; m_pend_b = 1;
      m_num = 0; m_ts = 0; m_err_a = 0; m_err_b = 0; m_ovf = 0;
      m_cnt_a = 0; m_cnt_b = 0;
      m_log.delete();
   endtask

   task automatic model_clock();
      int v, top3, bit1, msb, f, entry;
      bit is_ts, is_fill, unk;
      v       = int'(info);
      top3    = v / 8;
      bit1    = (v / 2) % 2;
      msb     = v / 32;
      f       = (v / 8) % 4;
      is_ts   = valid && (top3 == 1) && (bit1 == 1);
      is_fill = valid && (msb == 1) && (bit1 == 0) && (f != 0);
      unk     = valid && !is_ts && !is_fill;
      entry   = (evt ? 64 : 0) + v;

      m_err_a = (m_cnt_a > longint'(thres)) ? 1 : 0;
      m_err_b = (m_cnt_b > int'(thres % 16)) ? 1 : 0;
      if (clr) begin
         m_cnt_a = 0;
         m_cnt_b = 0;
      end else if (unk) begin
         if (m_cnt_a < 64'hFFFF_FFFF) m_cnt_a++;
         if (m_cnt_b < 15) m_cnt_b++;
      end

      m_num = (valid && evt) ? 1 : 0;
      m_ts  = is_ts ? 1 : 0;

      if (fs) m_fill_a = m_pend_a;
      if (is_fill) begin
         m_pend_a = f;
         m_pend_b = f;
         m_fill_b = f;
      end

      if (rd && m_log.size() > 0) void'(m_log.pop_front());
      if (valid) begin
         if (m_log.size() < DEPTH) m_log.push_back(entry);
         else m_ovf = 1;
      end
   endtask

   task automatic check_all();
      chk("fill_type_a", 64'(bus_a.fill_type), 64'(m_fill_a));
      chk("pending_a", 64'(bus_a.fill_type_pending), 64'(m_pend_a));
      chk("fill_type_b", 64'(bus_b.fill_type), 64'(m_fill_b));
      chk("pending_b", 64'(bus_b.fill_type_pending), 64'(m_pend_b));
      chk("trig_num_a", 64'(bus_a.reset_trig_num), 64'(m_num));
      chk("trig_ts_a", 64'(bus_a.reset_trig_timestamp), 64'(m_ts));
      chk("trig_num_b", 64'(bus_b.reset_trig_num), 64'(m_num));
      chk("trig_ts_b", 64'(bus_b.reset_trig_timestamp), 64'(m_ts));
      chk("count_a", 64'(bus_a.unknown_cmd_count), 64'(m_cnt_a));
      chk("count_b", 64'(bus_b.unknown_cmd_count), 64'(m_cnt_b));
      chk("err_a", 64'(bus_a.error_unknown), 64'(m_err_a));
      chk("err_b", 64'(bus_b.error_unknown), 64'(m_err_b));
`ifdef TTC_CHANB_LOG_EN
      chk("log_empty_a", 64'(bus_a.log_empty), 64'(m_log.size() == 0));
      chk("log_empty_b", 64'(bus_b.log_empty), 64'(m_log.size() == 0));
      chk("log_ovf_a", 64'(bus_a.log_overflow), 64'(m_ovf));
      chk("log_ovf_b", 64'(bus_b.log_overflow), 64'(m_ovf));
      if (m_log.size() > 0) begin
         chk("log_dout_a", 64'(bus_a.log_dout), 64'(m_log[0]));
         chk("log_dout_b", 64'(bus_b.log_dout), 64'(m_log[0]));
      end
`else
      chk("log_empty_tie", 64'(bus_a.log_empty), 64'(1));
      chk("log_dout_tie", 64'(bus_a.log_dout), 64'(0));
      chk("log_ovf_tie", 64'(bus_a.log_overflow), 64'(0));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else model_clock();
      #1;
      check_all();
   endtask

   task automatic strobe(input logic [5:0] cmd, input logic e);
      info  = cmd;
      evt   = e;
      valid = 1'b1;
      step();
      valid = 1'b0;
      evt   = 1'b0;
   endtask

   initial begin
      reset = 1'b1; info = '0; valid = 1'b0; evt = 1'b0; fs = 1'b0;
      clr = 1'b0; rd = 1'b0; thres = 32'd100;
      model_reset();

      // Reset, then idle
      step(); step();
      reset = 1'b0;
      step(); step();
      chk("rst_fill_a", 64'(bus_a.fill_type), 64'd1);
      chk("rst_count_a", 64'(bus_a.unknown_cmd_count), 64'd0);
      chk("rst_err_a", 64'(bus_a.error_unknown), 64'd0);

      // Deferred vs immediate fill change
      strobe(6'b110000, 1'b0);
      chk("defer_pend_a", 64'(bus_a.fill_type_pending), 64'd2);
      chk("defer_hold_a", 64'(bus_a.fill_type), 64'd1);
      chk("immed_fill_b", 64'(bus_b.fill_type), 64'd2);
      fs = 1'b1; step(); fs = 1'b0;
      chk("fill_start_a", 64'(bus_a.fill_type), 64'd2);

      // Fill start coinciding with a new fill command
      info = 6'b101000; valid = 1'b1; fs = 1'b1; step(); valid = 1'b0; fs = 1'b0;
      chk("coincide_fill_a", 64'(bus_a.fill_type), 64'd2);
      chk("coincide_pend_a", 64'(bus_a.fill_type_pending), 64'd1);

      // Timestamp command with event-counter reset
      strobe(6'b001010, 1'b1);
      chk("ts_pulse", 64'(bus_a.reset_trig_timestamp), 64'd1);
      chk("num_pulse", 64'(bus_a.reset_trig_num), 64'd1);
      chk("ts_no_count", 64'(bus_a.unknown_cmd_count), 64'd0);
      step();
      chk("ts_one_cycle", 64'(bus_a.reset_trig_timestamp), 64'd0);

      // Unknown commands against a threshold, then clear
      thres = 32'd2;
      strobe(6'b000000, 1'b0);
      strobe(6'b000000, 1'b0);
      strobe(6'b000000, 1'b0);
      chk("unk_count3", 64'(bus_a.unknown_cmd_count), 64'd3);
      step();
      chk("unk_err", 64'(bus_a.error_unknown), 64'd1);
      clr = 1'b1; valid = 1'b1; info = 6'b000000; step(); clr = 1'b0; valid = 1'b0;
      step();
      chk("clr_count", 64'(bus_a.unknown_cmd_count), 64'd0);
      chk("clr_err", 64'(bus_a.error_unknown), 64'd0);

      // Saturation of the 4-bit counter
      for (int i = 0; i < 20; i++) strobe(6'b100000, 1'b0);
      chk("sat_count_b", 64'(bus_b.unknown_cmd_count), 64'd15);
      chk("nosat_count_a", 64'(bus_a.unknown_cmd_count), 64'd20);

      // Log fill to overflow and drain in order
      reset = 1'b1; step(); reset = 1'b0;
      for (int k = 1; k <= 5; k++) strobe(6'(k), logic'(k % 2));
`ifdef TTC_CHANB_LOG_EN
      chk("log_ovf_set", 64'(bus_a.log_overflow), 64'd1);
      rd = 1'b1;
      chk("log_rd0", 64'(bus_a.log_dout), 64'h41); step();
      chk("log_rd1", 64'(bus_a.log_dout), 64'h02); step();
      chk("log_rd2", 64'(bus_a.log_dout), 64'h43); step();
      chk("log_rd3", 64'(bus_a.log_dout), 64'h04); step();
      chk("log_drained", 64'(bus_a.log_empty), 64'd1);
      step();
      rd = 1'b0;
`else
      chk("nolog_ovf", 64'(bus_a.log_overflow), 64'd0);
      chk("nolog_empty", 64'(bus_a.log_empty), 64'd1);
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         valid = 1'($urandom_range(0, 1));
         info  = 6'($urandom);
         evt   = ($urandom_range(0, 3) == 0);
         fs    = ($urandom_range(0, 7) == 0);
         clr   = ($urandom_range(0, 31) == 0);
         rd    = ($urandom_range(0, 2) == 0);
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 63) == 0) thres = $urandom_range(0, 20);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ttc_chanb_cmd_decoder.md
TTC_CHANB_CMD_DECODER -- requirements
Module: ttc_chanb_cmd_decoder

Interface
REQ-001 SHALL have parameter CMD_W, default 6: broadcast command width (Brcst[7:2]); must satisfy CMD_W >= FILL_TYPE_W+3.
REQ-002 SHALL have parameter FILL_TYPE_W, default 2: fill-type field width.
REQ-003 SHALL have parameter CNT_W, default 32: unknown-command counter and threshold width.
REQ-004 SHALL have parameter DEFER_FILL, default 1: 1 = fill-type change takes effect at next fill_start; 0 = takes effect immediately.
REQ-005 SHALL have parameter LOG_DEPTH, default 16: command log depth, power of two.
REQ-006 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port chan_b_info  input  CMD_W  broadcast command bits.
REQ-009 SHALL have port chan_b_valid  input  1  broadcast strobe.
REQ-010 SHALL have port evt_count_reset  input  1  event-counter-reset bit, qualified by chan_b_valid.
REQ-011 SHALL have port fill_start  input  1  one-cycle pulse marking a fill boundary.
REQ-012 SHALL have port thres_unknown  input  CNT_W  unknown-command error threshold.
REQ-013 SHALL have port err_clr  input  1  clears unknown counter and error flag.
REQ-014 SHALL have port fill_type  output  FILL_TYPE_W  active fill type.
REQ-015 SHALL have port fill_type_pending  output  FILL_TYPE_W  staged fill type.
REQ-016 SHALL have port reset_trig_num  output  1  registered pulse.
REQ-017 SHALL have port reset_trig_timestamp  output  1  registered pulse.
REQ-018 SHALL have port unknown_cmd_count  output  CNT_W  saturating count.
REQ-019 SHALL have port error_unknown  output  1  registered flag, count > threshold.
REQ-020 SHALL have ports log_rd_en input 1, log_dout output CMD_W+1 ({evt_count_reset, chan_b_info}), log_empty output 1, log_overflow output 1 (sticky).

Function
REQ-021 SHALL assert reset_trig_num for exactly one cycle, one clk after a cycle with chan_b_valid && evt_count_reset, independent of command decode.
REQ-022 SHALL assert reset_trig_timestamp one clk after chan_b_valid with chan_b_info[CMD_W-1:CMD_W-3]==3'b001 and chan_b_info[1]==1.
REQ-023 SHALL decode a fill command when chan_b_valid, chan_b_info[CMD_W-1]==1, chan_b_info[1]==0, and field F = chan_b_info[CMD_W-2 -: FILL_TYPE_W] is nonzero; F==0 counts as unknown.
REQ-024 SHALL, on a fill command, load F into fill_type_pending next cycle; when DEFER_FILL=0, also load fill_type in that same cycle.
REQ-025 SHALL, when DEFER_FILL=1, copy fill_type_pending to fill_type one clk after fill_start.
REQ-026 SHALL, when fill_start and a fill command coincide, load the old pending value into fill_type and the new F into fill_type_pending.
REQ-027 SHALL increment unknown_cmd_count by 1 for each valid strobe that is neither a fill command nor a timestamp command; the count saturates at 2^CNT_W-1.
REQ-028 SHALL give err_clr priority over an increment in the same cycle; the count becomes 0.
REQ-029 SHALL register error_unknown from the count, one clk after the count changes.

Reset
REQ-030 SHALL, on reset, set fill_type = fill_type_pending = 1 (muon fill).
REQ-031 SHALL, on reset, set unknown_cmd_count = 0 and error_unknown = 0.
REQ-032 SHALL, on reset, set reset_trig_num = reset_trig_timestamp = 0.
REQ-033 SHALL, on reset, empty the log and clear log_overflow; reset overrides all inputs, including a mid-fill reset.

Configuration
REQ-034 SHALL, with TTC_CHANB_LOG_EN defined, write {evt_count_reset, chan_b_info} into a LOG_DEPTH FIFO on every chan_b_valid.
REQ-035 SHALL present the log head as first-word fall-through on log_dout, and pop on log_rd_en && !log_empty.
REQ-036 SHALL ignore reads when the log is empty.
REQ-037 SHALL, when the log is full, drop the write and set log_overflow, unless a pop occurs in the same cycle, in which case the write is accepted.
REQ-038 SHALL, without TTC_CHANB_LOG_EN, instantiate no storage and tie log_empty=1, log_dout=0, log_overflow=0.

Verification
REQ-039 SHALL verify: reset, then no strobes -> fill_type=1, count=0, error_unknown=0.
REQ-040 SHALL verify: DEFER_FILL=1, strobe info=6'b110000 -> pending=2 next cycle, fill_type stays 1; fill_start -> fill_type=2 one clk later.
REQ-041 SHALL verify: strobe info=6'b001010 with evt_count_reset=1 -> reset_trig_timestamp and reset_trig_num high together for one cycle, count unchanged.
REQ-042 SHALL verify: thres_unknown=2, three strobes info=6'b000000 -> count=3, error_unknown=1; err_clr -> 0/0.
REQ-043 SHALL verify: CNT_W=4, 20 unknown strobes -> count holds at 15.
REQ-044 SHALL verify: TTC_CHANB_LOG_EN, LOG_DEPTH=4, 5 strobes without reads -> first 4 entries read back in order, log_overflow=1.
